multicycle_main_fsm: RTL and testbench

Multicycle main control unit for the RV32 core. It replaces the single-cycle main decoder with a registered state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It arbitrates a single shared instruction/data memory through a ready handshake and adds JALR and AUIPC support. It also adds a bus timeout, sticky illegal/bus-error halting, and a retired-instruction counter.

---
 rtl/multicycle_main_fsm.sv | 270 +++++++++++++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32 main control unit: sequences fetch/decode/execute/memory/writeback
// over one shared memory with a ready handshake, bus timeout and retire counter.
module multicycle_main_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             RegWrite,
    output logic [2:0]       ImmSrc,
    output logic [1:0]       ALU_srcA,
    output logic [1:0]       ALU_srcB,
    output logic [2:0]       ALU_op,
    output logic [1:0]       Result_src,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TO_EN  = (TIMEOUT != 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_CMP  = 3'b100;
    localparam logic [2:0] ALU_SPEC = 3'b111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_HALT     = 4'd14
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               timeout_c;

    // only funct3[2] selects the branch comparison
    logic unused_funct3;
    assign unused_funct3 = ^funct3[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    assign timeout_c = TO_EN && (wait_q == WAIT_W'(TIMEOUT)) && !mem_ready;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        instret_d  = instret_q;
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        ImmSrc     = IMM_I;
        ALU_srcA   = SRCA_PC;
        ALU_srcB   = SRCB_RS2;
        ALU_op     = ALU_ADD;
        Result_src = RES_ALUOUT;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                ALU_srcB   = SRCB_FOUR;
                Result_src = RES_ALURES;
                IRWrite    = mem_ready;
                PCUpdate   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                ALU_srcA = SRCA_OLDPC;
                ALU_srcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH: begin
                        ImmSrc  = IMM_B;
                        state_d = S_BRANCH;
                    end
                    OP_JAL: begin
                        ImmSrc  = IMM_J;
                        state_d = S_JAL;
                    end
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALU_srcA = SRCA_RS1;
                ALU_srcB = SRCB_IMM;
                ImmSrc   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_c) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_MEMWB: begin
                Result_src = RES_RDATA;
                RegWrite   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_c) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_EXECR: begin
                ALU_srcA = SRCA_RS1;
                ALU_op   = ALU_SPEC;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                ALU_srcA = SRCA_RS1;
                ALU_srcB = SRCB_IMM;
                ALU_op   = ALU_SPEC;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALU_srcA = SRCA_RS1;
                Branch   = 1'b1;
                ALU_op   = funct3[2] ? ALU_CMP : ALU_SUB;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                ALU_srcA = SRCA_OLDPC;
                ALU_srcB = SRCB_FOUR;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_JALR: begin
                ALU_srcA = SRCA_RS1;
                ALU_srcB = SRCB_IMM;
                state_d  = S_JAL;
            end
            S_LUI: begin
                ImmSrc     = IMM_U;
                Result_src = RES_IMM;
                RegWrite   = 1'b1;
                state_d    = S_FETCH;
            end
            S_AUIPC: begin
                ALU_srcA = SRCA_OLDPC;
                ALU_srcB = SRCB_IMM;
                ImmSrc   = IMM_U;
                state_d  = S_ALUWB;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        // wait counter restarts whenever the state changes, counts idle request cycles
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (!mem_ready &&
                     (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE)) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        if (state_d == S_FETCH &&
            (state_q == S_MEMWB || state_q == S_MEMWRITE || state_q == S_ALUWB ||
             state_q == S_BRANCH || state_q == S_LUI)) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    assign state   = 4'(state_q);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed scenarios plus a random
// instruction stream checked against an instruction-level sequence model.
module tb_multicycle_main_fsm;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic          clk;
    logic          reset;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          mem_ready;
    logic          mem_req, AdrSrc, MemWrite, IRWrite, PCUpdate, Branch, RegWrite;
    logic [2:0]    ImmSrc;
    logic [1:0]    ALU_srcA, ALU_srcB;
    logic [2:0]    ALU_op;
    logic [1:0]    Result_src;
    logic          illegal, bus_err;
    logic [CW-1:0] instret;
    logic [3:0]    state;
    logic [20:0]   obs;

    int errors;
    int checks;

    multicycle_main_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
        .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB), .ALU_op(ALU_op), .Result_src(Result_src),
        .illegal(illegal), .bus_err(bus_err), .instret(instret), .state(state)
    );

    assign obs = {illegal, bus_err, mem_req, AdrSrc, MemWrite, IRWrite, PCUpdate, Branch,
                  RegWrite, ImmSrc, ALU_srcA, ALU_srcB, ALU_op, Result_src};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Control word each state must present, read straight off the state table
    function automatic logic [18:0] exp_out(input int st, input logic [6:0] op,
                                            input logic [2:0] f3, input logic rdy);
        logic       req, adr, mw, irw, pcu, br, rw;
        logic [2:0] imm, aop;
        logic [1:0] sa, sb, rs;
        req = 0; adr = 0; mw = 0; irw = 0; pcu = 0; br = 0; rw = 0;
        imm = 3'b000; aop = 3'b000; sa = 2'b00; sb = 2'b00; rs = 2'b00;
        case (st)
            0:  begin req = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcu = rdy; end
            1:  begin sa = 2'b01; sb = 2'b01;
                      imm = (op == OP_BRANCH) ? 3'b010 : (op == OP_JAL) ? 3'b011 : 3'b000; end
            2:  begin sa = 2'b10; sb = 2'b01; imm = (op == OP_STORE) ? 3'b001 : 3'b000; end
            3:  begin req = 1; adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin req = 1; adr = 1; mw = 1; end
            6:  begin sa = 2'b10; aop = 3'b111; end
            7:  begin sa = 2'b10; sb = 2'b01; aop = 3'b111; end
            8:  begin rw = 1; end
            9:  begin sa = 2'b10; br = 1; aop = f3[2] ? 3'b100 : 3'b001; end
            10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            11: begin sa = 2'b10; sb = 2'b01; end
            12: begin imm = 3'b100; rs = 2'b11; rw = 1; end
            13: begin sa = 2'b01; sb = 2'b01; imm = 3'b100; end
            default: ;
        endcase
        return {req, adr, mw, irw, pcu, br, rw, imm, sa, sb, aop, rs};
    endfunction

    function automatic logic junk();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT at the start of a fresh FETCH cycle
    task automatic apply_reset();
        reset = 1'b1;
        mem_ready = junk();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (instret !== '0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        checks++; if ({illegal, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b expected 00", {illegal, bus_err}); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_mem_req: got %b expected 1", mem_req); end
        tick();
    endtask

    task automatic test_add();
        int exp_st[4] = '{0, 1, 6, 8};
        apply_reset();
        funct3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            opcode = OP_R; mem_ready = 1'b1; #1;
            checks++; if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL add_state c%0d: got %0d expected %0d", i, state, exp_st[i]); end
            checks++; if (RegWrite !== (exp_st[i] == 8)) begin errors++; $display("FAIL add_regwrite c%0d: got %b expected %b", i, RegWrite, exp_st[i] == 8); end
            checks++; if (instret !== '0) begin errors++; $display("FAIL add_instret_early c%0d: got %0d expected 0", i, instret); end
            tick();
        end
        mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL add_end_state: got %0d expected 0", state); end
        checks++; if (instret !== CW'(1)) begin errors++; $display("FAIL add_instret: got %0d expected 1", instret); end
    endtask

    task automatic test_lw_wait();
        int   exp_st[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        logic rdy[8]    = '{1, 0, 0, 0, 0, 0, 1, 0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            opcode = OP_LOAD; funct3 = 3'b010; mem_ready = rdy[i]; #1;
            checks++; if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL lw_state c%0d: got %0d expected %0d", i, state, exp_st[i]); end
            if (exp_st[i] == 3) begin
                checks++; if (AdrSrc !== 1'b1) begin errors++; $display("FAIL lw_adrsrc c%0d: got %b expected 1", i, AdrSrc); end
            end
            tick();
        end
        mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_end_state: got %0d expected 0", state); end
        checks++; if (instret !== CW'(1)) begin errors++; $display("FAIL lw_instret: got %0d expected 1", instret); end
    endtask

    task automatic test_jalr();
        int exp_st[5] = '{0, 1, 11, 10, 8};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            opcode = OP_JALR; funct3 = 3'b000; mem_ready = 1'b1; #1;
            checks++; if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL jalr_state c%0d: got %0d expected %0d", i, state, exp_st[i]); end
            checks++; if (PCUpdate !== (exp_st[i] == 0 || exp_st[i] == 10)) begin errors++; $display("FAIL jalr_pcupdate c%0d: got %b", i, PCUpdate); end
            if (exp_st[i] == 11) begin
                checks++; if (ImmSrc !== 3'b000) begin errors++; $display("FAIL jalr_immsrc: got %b expected 000", ImmSrc); end
            end
            tick();
        end
        mem_ready = 1'b0; #1;
        checks++; if (instret !== CW'(1)) begin errors++; $display("FAIL jalr_instret: got %0d expected 1", instret); end
    endtask

    task automatic test_branch();
        logic [2:0] f3s[2] = '{3'b101, 3'b000};
        for (int b = 0; b < 2; b++) begin
            apply_reset();
            for (int i = 0; i < 3; i++) begin
                opcode = OP_BRANCH; funct3 = f3s[b]; mem_ready = 1'b1; #1;
                checks++; if (state !== 4'(i == 2 ? 9 : i)) begin errors++; $display("FAIL br_state f3=%b c%0d: got %0d", f3s[b], i, state); end
                if (i == 2) begin
                    checks++; if (ALU_op !== (f3s[b][2] ? 3'b100 : 3'b001)) begin errors++; $display("FAIL br_aluop f3=%b: got %b", f3s[b], ALU_op); end
                    checks++; if (Branch !== 1'b1) begin errors++; $display("FAIL br_branch f3=%b: got %b expected 1", f3s[b], Branch); end
                end
                tick();
            end
            mem_ready = 1'b0; #1;
            checks++; if (state !== 4'd0 || instret !== CW'(1)) begin errors++; $display("FAIL br_retire: state %0d instret %0d expected 0/1", state, instret); end
        end
    endtask

    task automatic test_illegal();
        int         exp_st[5] = '{0, 1, 12, 0, 1};
        logic [6:0] ops[5]    = '{OP_LUI, OP_LUI, OP_LUI, OP_BAD, OP_BAD};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i]; funct3 = 3'b000; mem_ready = 1'b1; #1;
            checks++; if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL ill_state c%0d: got %0d expected %0d", i, state, exp_st[i]); end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            mem_ready = junk(); #1;
            checks++; if (state !== 4'd14 || mem_req !== 1'b0 || illegal !== 1'b1) begin
                errors++; $display("FAIL ill_halt c%0d: state %0d mem_req %b illegal %b", i, state, mem_req, illegal); end
            checks++; if (instret !== CW'(1)) begin errors++; $display("FAIL ill_instret c%0d: got %0d expected 1", i, instret); end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0 || illegal !== 1'b0 || instret !== '0) begin
            errors++; $display("FAIL ill_reset: state %0d illegal %b instret %0d expected 0/0/0", state, illegal, instret); end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            opcode = 7'($urandom); mem_ready = 1'b0; #1;
            checks++; if (state !== 4'd0 || bus_err !== 1'b0) begin errors++; $display("FAIL to_wait c%0d: state %0d bus_err %b", i, state, bus_err); end
            tick();
        end
        #1;
        checks++; if (state !== 4'd14 || bus_err !== 1'b1) begin errors++; $display("FAIL to_halt: state %0d bus_err %b expected 14/1", state, bus_err); end
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            opcode = OP_LUI; mem_ready = (i == 4); #1;
            if (i == 4) begin
                checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL to_late_irwrite: got %b expected 1", IRWrite); end
            end
            tick();
        end
        #1;
        checks++; if (state !== 4'd1 || bus_err !== 1'b0) begin errors++; $display("FAIL to_late_decode: state %0d bus_err %b expected 1/0", state, bus_err); end
        tick(); tick();
        mem_ready = 1'b0; #1;
        checks++; if (instret !== CW'(1)) begin errors++; $display("FAIL to_late_instret: got %0d expected 1", instret); end
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            opcode = OP_STORE; mem_ready = (i == 0); #1;
            if (i >= 3) begin
                checks++; if (state !== 4'd5 || MemWrite !== 1'b1) begin errors++; $display("FAIL to_st_wait c%0d: state %0d MemWrite %b", i, state, MemWrite); end
            end
            tick();
        end
        mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd14 || bus_err !== 1'b1 || MemWrite !== 1'b0 || instret !== '0) begin
            errors++; $display("FAIL to_st_halt: state %0d bus_err %b MemWrite %b instret %0d", state, bus_err, MemWrite, instret); end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            opcode = OP_STORE; mem_ready = (i == 0); #1;
            tick();
        end
        reset = 1'b1; mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd5 || MemWrite !== 1'b1) begin errors++; $display("FAIL mid_pre: state %0d MemWrite %b expected 5/1", state, MemWrite); end
        tick();
        reset = 1'b0; #1;
        checks++; if (state !== 4'd0 || MemWrite !== 1'b0 || instret !== '0) begin
            errors++; $display("FAIL mid_post: state %0d MemWrite %b instret %0d expected 0/0/0", state, MemWrite, instret); end
    endtask

    // Random legal instruction stream; the model lists each instruction's state path
    task automatic test_random();
        int         sq[$];
        logic       rq[$];
        int         exp_ret;
        int         cls, wf, wm;
        logic [6:0] op;
        logic [2:0] f3;
        logic [18:0] ex;
        exp_ret = 0;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            cls = $urandom_range(0, 8);
            f3  = 3'($urandom_range(0, 7));
            wf  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TO) : 0;
            wm  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TO) : 0;
            sq.delete(); rq.delete();
            for (int k = 0; k < wf; k++) begin sq.push_back(0); rq.push_back(1'b0); end
            sq.push_back(0); rq.push_back(1'b1);
            sq.push_back(1); rq.push_back(junk());
            case (cls)
                0: begin
                    op = OP_LOAD; sq.push_back(2); rq.push_back(junk());
                    for (int k = 0; k < wm; k++) begin sq.push_back(3); rq.push_back(1'b0); end
                    sq.push_back(3); rq.push_back(1'b1);
                    sq.push_back(4); rq.push_back(junk());
                end
                1: begin
                    op = OP_STORE; sq.push_back(2); rq.push_back(junk());
                    for (int k = 0; k < wm; k++) begin sq.push_back(5); rq.push_back(1'b0); end
                    sq.push_back(5); rq.push_back(1'b1);
                end
                2: begin op = OP_R;      sq.push_back(6);  sq.push_back(8); rq.push_back(junk()); rq.push_back(junk()); end
                3: begin op = OP_I;      sq.push_back(7);  sq.push_back(8); rq.push_back(junk()); rq.push_back(junk()); end
                4: begin op = OP_BRANCH; sq.push_back(9);  rq.push_back(junk()); end
                5: begin op = OP_JAL;    sq.push_back(10); sq.push_back(8); rq.push_back(junk()); rq.push_back(junk()); end
                6: begin
                    op = OP_JALR; sq.push_back(11); sq.push_back(10); sq.push_back(8);
                    rq.push_back(junk()); rq.push_back(junk()); rq.push_back(junk());
                end
                7: begin op = OP_LUI;    sq.push_back(12); rq.push_back(junk()); end
                default: begin op = OP_AUIPC; sq.push_back(13); sq.push_back(8); rq.push_back(junk()); rq.push_back(junk()); end
            endcase
            for (int j = 0; j < sq.size(); j++) begin
                opcode = (sq[j] == 0) ? 7'($urandom) : op;
                funct3 = f3;
                mem_ready = rq[j];
                #1;
                ex = exp_out(sq[j], opcode, funct3, mem_ready);
                checks++; if (state !== 4'(sq[j])) begin errors++; $display("FAIL rnd_state i%0d c%0d op=%b: got %0d expected %0d", n, j, op, state, sq[j]); end
                checks++; if (obs !== {2'b00, ex}) begin errors++; $display("FAIL rnd_outputs i%0d c%0d st=%0d: got %h expected %h", n, j, sq[j], obs, {2'b00, ex}); end
                checks++; if (instret !== CW'(exp_ret)) begin errors++; $display("FAIL rnd_instret i%0d c%0d: got %0d expected %0d", n, j, instret, exp_ret); end
                tick();
            end
            exp_ret = (exp_ret + 1) % (1 << CW);
        end
        mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0 || instret !== CW'(exp_ret)) begin
            errors++; $display("FAIL rnd_final: state %0d instret %0d expected 0/%0d", state, instret, exp_ret); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        opcode = '0;
        funct3 = '0;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_jalr();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
